lut_h_gen: RTL
==============

# lut_h_gen

Sequential generator and checker for the 16-entry high-nibble reduction table used by the NTT modular-reduction path (q = 3329). Entry k holds (−STEP·k) mod Q: 0, 3270, 3211, … 2444. On `start` it streams all entries over a valid/ready write port into a RAM-backed table. If `verify` is set, it then reads the table back through a 1-cycle-latency read port and flags the first mismatch. It is the writer/checker counterpart of the table's combinational readers.

## Interface
- `Q`, 3329, modulus
- `STEP`, 59, per-entry decrement (mod Q)
- `DEPTH`, 16, entries; address width = log2(DEPTH)
- `DW`, 12, data width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run; honoured only in IDLE
- `verify`  in  1  sampled with `start`; 1 = readback after write
- `busy`  out  1  high in WRITE/READ
- `done`  out  1  one-cycle pulse at end of run
- `err`  out  1  sticky mismatch flag; cleared by accepted `start`
- `err_addr`  out  4  address of first mismatch
- `wr_valid`  out  1  write request
- `wr_ready`  in  1  sink accepts
- `wr_addr`  out  4  entry index
- `wr_data`  out  DW  entry value
- `rd_en`  out  1  read strobe
- `rd_addr`  out  4  read index
- `rd_data`  in  DW  data for the `rd_addr` presented on the previous cycle

## Operation
- States: IDLE → WRITE → (READ if verify) → DONE → IDLE.
- IDLE: `start`=1 clears `err`/`err_addr`, latches `verify`, resets index k=0 and accumulator v=0.
- WRITE: `wr_valid`=1 with `wr_addr`=k and `wr_data`=v.
  - On `wr_valid & wr_ready`: k++ and v advances.
  - Address and data stay stable while `wr_ready`=0.
  - After k=DEPTH−1 is accepted: go to READ if verify, else DONE.
- Accumulator step: v' = (v ≥ STEP) ? v − STEP : v + Q − STEP.
  - Compute in DW+1 bits; v is always < Q.
- READ runs DEPTH+1 cycles and restarts k and v at 0 on entry.
  - Cycles 0..DEPTH−1: `rd_en`=1, `rd_addr`=k.
  - Cycles 1..DEPTH: compare `rd_data` against the expected value, delayed one stage.
  - On the first mismatch, set `err`=1 and `err_addr` to that index. Later mismatches do not update `err_addr`.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE, including in DONE.
- Reset value of every output is 0.
- Asynchronous reset mid-run aborts immediately. The next `start` restarts from addr 0.

## Timing
- `start` sampled at cycle 0 → first `wr_valid` at cycle 1.
- With `wr_ready` held at 1: 16 write cycles (1..16).
  - No verify: `done` at cycle 17.
  - Verify: READ occupies cycles 17..33, `done` at cycle 34.
- `busy` rises at cycle 1 and falls in the DONE cycle.
- `err` is valid no later than the `done` cycle.
- `rd_en` and `wr_valid` are never high in the same cycle.

## Structure
- Package `lut_h_pkg`:
  - Q, STEP, DEPTH, DW.
  - State enum {IDLE, WRITE, READ, DONE}.
  - Function `mod_step(v)` implementing the accumulator step.
- Sub-module `lut_h_acc`: holds the modular accumulator register. Inputs: clear, advance. Output: v. One instance in the top level.
- Top level holds the FSM, index counter, read-compare pipeline stage, and error registers.

## Test plan
- Plain write: `wr_ready`≡1, `verify`=0.
  - Addresses 0..15 carry 0, 3270, 3211, 3152, 3093, 3034, 2975, 2916, 2857, 2798, 2739, 2680, 2621, 2562, 2503, 2444.
  - `done` at cycle 17, `err`=0.
- Backpressure: `wr_ready`=0 for 3 cycles while addr 5 is presented.
  - `wr_addr`=5 and `wr_data`=3034 hold stable.
  - `done` is delayed by 3 cycles (cycle 20).
- Verify, correct memory model: `err`=0; `done` at cycle 34; `rd_addr` sweeps 0..15 during cycles 17..32.
- Verify, corrupted memory: model returns 2799 at addr 9 and a wrong value at addr 12.
  - `err`=1 and `err_addr`=9 at `done`.
  - A following `start` clears `err`.
- Reset and ignored start:
  - Assert `rst_n`=0 at addr 7 mid-write: all outputs go to 0 immediately.
  - A new run begins at addr 0 with data 0.
  - Pulsing `start` during WRITE or DONE has no effect.

Source files
------------

// File: rtl/lut_h_pkg.sv
// Shared constants, state encoding and the modular step for the
// high-nibble reduction table writer/checker.
package lut_h_pkg;

  localparam int unsigned Q     = 3329;
  localparam int unsigned STEP  = 59;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 12;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One table step: v' = (v - STEP) mod Q, computed one bit wider so the
  // wrap-around add of Q cannot overflow. Input must already be < Q.
  function automatic logic [DW-1:0] mod_step(input logic [DW-1:0] v);
    logic [DW:0] wide;
    wide = {1'b0, v};
    if (wide >= (DW+1)'(STEP)) begin
      wide = wide - (DW+1)'(STEP);
    end else begin
      wide = wide + (DW+1)'(Q) - (DW+1)'(STEP);
    end
    return wide[DW-1:0];
  endfunction

endpackage

// File: rtl/lut_h_acc.sv
// Modular accumulator producing successive table entries (-STEP*k) mod Q.
module lut_h_acc
  import lut_h_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [DW-1:0] v
);

  // Clear has priority so a restart in the same cycle as a step wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (clear) begin
      v <= '0;
    end else if (advance) begin
      v <= mod_step(v);
    end
  end

endmodule

// File: rtl/lut_h_gen.sv
// Writes the 16-entry reduction table over a valid/ready port and can read
// it back through a 1-cycle-latency port, flagging the first mismatch.
module lut_h_gen
  import lut_h_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          verify,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_addr,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data
);

  state_t        state;
  // One extra index bit marks the final READ cycle, which only compares.
  logic [AW:0]   idx;
  logic          verify_q;
  logic          cmp_valid;
  logic [AW-1:0] cmp_addr;
  logic [DW-1:0] cmp_exp;
  logic [DW-1:0] v;
  logic          wr_fire;
  logic          wr_last;
  logic          acc_clr;
  logic          acc_adv;

  lut_h_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (acc_clr),
    .advance (acc_adv),
    .v       (v)
  );

  // Port outputs and accumulator control decoded from state; buses are
  // gated to zero when their strobe is low so idle/reset outputs are 0.
  always_comb begin
    busy     = (state == WRITE) || (state == READ);
    done     = (state == DONE);
    wr_valid = (state == WRITE);
    wr_addr  = wr_valid ? idx[AW-1:0] : '0;
    wr_data  = wr_valid ? v : '0;
    rd_en    = (state == READ) && !idx[AW];
    rd_addr  = rd_en ? idx[AW-1:0] : '0;
    wr_fire  = wr_valid && wr_ready;
    wr_last  = wr_fire && (idx[AW-1:0] == '1);
    acc_clr  = ((state == IDLE) && start) || wr_last;
    acc_adv  = wr_fire || rd_en;
  end

  // Sequencer, index counter, read-compare stage and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      verify_q  <= 1'b0;
      err       <= 1'b0;
      err_addr  <= '0;
      cmp_valid <= 1'b0;
      cmp_addr  <= '0;
      cmp_exp   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= WRITE;
            idx      <= '0;
            verify_q <= verify;
            err      <= 1'b0;
            err_addr <= '0;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            idx <= idx + 1'b1;
            if (wr_last) begin
              idx   <= '0;
              state <= verify_q ? READ : DONE;
            end
          end
        end
        READ: begin
          // Expected value travels alongside the address so it lines up
          // with rd_data one cycle later.
          cmp_valid <= rd_en;
          cmp_addr  <= idx[AW-1:0];
          cmp_exp   <= v;
          if (cmp_valid && (rd_data != cmp_exp) && !err) begin
            err      <= 1'b1;
            err_addr <= cmp_addr;
          end
          idx <= idx + 1'b1;
          if (idx[AW]) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
